// File: rtl/cache_ctrl_fsm_p.sv
// rtl/cache_ctrl_fsm_p.sv - parametrised direct-mapped cache controller FSM
// Dirty victims leave as a write burst, lines arrive as a read burst, then the access re-compares.
module cache_ctrl_fsm_p #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_W    = 8,
  parameter int CNT_W      = 32,
  localparam int BYTE_W    = $clog2(WORD_W / 8),
  localparam int BEAT_W    = $clog2(LINE_WORDS),
  localparam int OFF_W     = BEAT_W + BYTE_W,
  localparam int TAG_W     = ADDR_W - INDEX_W - OFF_W,
  localparam int LINE_W    = LINE_WORDS * WORD_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_valid_i,
  input  logic              cpu_rw_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_wdata_i,
  output logic [WORD_W-1:0] cpu_rdata_o,
  output logic              cpu_ready_o,
  output logic [INDEX_W-1:0] index_o,
  input  logic [TAG_W-1:0]  tag_rd_i,
  input  logic              tag_valid_i,
  input  logic              tag_dirty_i,
  output logic              tag_we_o,
  output logic [TAG_W-1:0]  tag_wr_o,
  output logic              tag_valid_o,
  output logic              tag_dirty_o,
  input  logic [LINE_W-1:0] data_rd_i,
  output logic              data_we_o,
  output logic [LINE_W-1:0] data_wr_o,
  output logic              mem_req_valid_o,
  output logic              mem_req_rw_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [WORD_W-1:0] mem_req_wdata_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_rsp_valid_i,
  input  logic [WORD_W-1:0] mem_rsp_data_i,
  output logic              stall_o,
  output logic [CNT_W-1:0]  no_acc_o,
  output logic [CNT_W-1:0]  no_hit_o,
  output logic [CNT_W-1:0]  no_miss_o,
  output logic [CNT_W-1:0]  no_wb_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE,
    S_REFILL,
    S_INSTALL
  } state_e;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LINE_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;
  logic [CNT_W-1:0]  wb_q, wb_d;

  logic              inc_acc, inc_hit, inc_miss, inc_wb;
  logic [TAG_W-1:0]  addr_tag;
  logic [INDEX_W-1:0] addr_idx;
  logic [BEAT_W-1:0] addr_word;
  logic              hit;
  logic              last_beat;
  logic [WORD_W-1:0] rd_words [LINE_WORDS];
  logic [LINE_W-1:0] merged_line;
  logic [LINE_W-1:0] fill_written;
  logic              unused_addr_bits;

  assign addr_tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign addr_idx         = cpu_addr_i[OFF_W +: INDEX_W];
  assign addr_word        = cpu_addr_i[BYTE_W +: BEAT_W];
  assign unused_addr_bits = ^cpu_addr_i[BYTE_W-1:0];
  assign hit              = tag_valid_i && (tag_rd_i == addr_tag);
  assign last_beat        = (beat_q == BEAT_W'(LINE_WORDS - 1));
  assign index_o          = addr_idx;

  // Word views of the stored line, the write-hit merge and the fill-buffer update.
  always_comb begin
    merged_line  = data_rd_i;
    fill_written = fill_q;
    for (int w = 0; w < LINE_WORDS; w++) begin
      rd_words[w] = data_rd_i[w*WORD_W +: WORD_W];
      if (BEAT_W'(w) == addr_word) merged_line[w*WORD_W +: WORD_W] = cpu_wdata_i;
      if (BEAT_W'(w) == beat_q)    fill_written[w*WORD_W +: WORD_W] = mem_rsp_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      fill_q  <= '0;
      acc_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    fill_d          = fill_q;
    inc_acc         = 1'b0;
    inc_hit         = 1'b0;
    inc_miss        = 1'b0;
    inc_wb          = 1'b0;
    cpu_rdata_o     = '0;
    cpu_ready_o     = 1'b0;
    tag_we_o        = 1'b0;
    tag_wr_o        = '0;
    tag_valid_o     = 1'b0;
    tag_dirty_o     = 1'b0;
    data_we_o       = 1'b0;
    data_wr_o       = '0;
    mem_req_valid_o = 1'b0;
    mem_req_rw_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;
    stall_o         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_valid_i) begin
          inc_acc = 1'b1;
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        if (hit) begin
          cpu_ready_o = 1'b1;
          cpu_rdata_o = rd_words[addr_word];
          inc_hit     = 1'b1;
          state_d     = S_IDLE;
          if (cpu_rw_i) begin
            data_we_o   = 1'b1;
            data_wr_o   = merged_line;
            tag_we_o    = 1'b1;
            tag_wr_o    = addr_tag;
            tag_valid_o = 1'b1;
            tag_dirty_o = 1'b1;
          end
        end else begin
          stall_o  = 1'b1;
          inc_miss = 1'b1;
          state_d  = (tag_valid_i && tag_dirty_i) ? S_WRITE_BACK : S_ALLOCATE;
        end
      end

      // Victim address comes from the stored tag, not the request tag.
      S_WRITE_BACK: begin
        stall_o         = 1'b1;
        mem_req_valid_o = 1'b1;
        mem_req_rw_o    = 1'b1;
        mem_req_addr_o  = {tag_rd_i, addr_idx, beat_q, {BYTE_W{1'b0}}};
        mem_req_wdata_o = rd_words[beat_q];
        if (mem_req_ready_i) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            inc_wb  = 1'b1;
            beat_d  = '0;
            state_d = S_ALLOCATE;
          end
        end
      end

      S_ALLOCATE: begin
        stall_o         = 1'b1;
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {addr_tag, addr_idx, {OFF_W{1'b0}}};
        if (mem_req_ready_i) state_d = S_REFILL;
      end

      S_REFILL: begin
        stall_o = 1'b1;
        if (mem_rsp_valid_i) begin
          fill_d = fill_written;
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_INSTALL;
          end
        end
      end

      S_INSTALL: begin
        stall_o     = 1'b1;
        data_we_o   = 1'b1;
        data_wr_o   = fill_q;
        tag_we_o    = 1'b1;
        tag_wr_o    = addr_tag;
        tag_valid_o = 1'b1;
        tag_dirty_o = 1'b0;
        state_d     = S_COMPARE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    acc_d  = acc_q;
    hit_d  = hit_q;
    miss_d = miss_q;
    wb_d   = wb_q;
    if (inc_acc  && (acc_q  != '1)) acc_d  = acc_q  + 1'b1;
    if (inc_hit  && (hit_q  != '1)) hit_d  = hit_q  + 1'b1;
    if (inc_miss && (miss_q != '1)) miss_d = miss_q + 1'b1;
    if (inc_wb   && (wb_q   != '1)) wb_d   = wb_q   + 1'b1;
  end

  assign no_acc_o  = acc_q;
  assign no_hit_o  = hit_q;
  assign no_miss_o = miss_q;
  assign no_wb_o   = wb_q;

endmodule

// File: tb/tb_cache_ctrl_fsm_p.sv
// tb/tb_cache_ctrl_fsm_p.sv - scoreboard bench for cache_ctrl_fsm_p
// Reference is a flat word memory plus a line directory; arrays and memory are bench models.
module tb_cache_ctrl_fsm_p;
  localparam int ADDR_W = 32, WORD_W = 32, LINE_WORDS = 4, INDEX_W = 8, CNT_W = 8;
  localparam int OFF_W = 4, TAG_W = ADDR_W - INDEX_W - OFF_W, LINE_W = LINE_WORDS * WORD_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               cpu_valid, cpu_rw;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [WORD_W-1:0]  cpu_wdata, cpu_rdata;
  logic               cpu_ready;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag_rd, tag_wr;
  logic               tag_valid_rd, tag_dirty_rd, tag_we, tag_valid_wr, tag_dirty_wr;
  logic [LINE_W-1:0]  data_rd, data_wr;
  logic               data_we;
  logic               mem_req_valid, mem_req_rw, mem_req_ready;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic [WORD_W-1:0]  mem_req_wdata, mem_rsp_data;
  logic               mem_rsp_valid;
  logic               stall;
  logic [CNT_W-1:0]   no_acc, no_hit, no_miss, no_wb;

  logic [TAG_W-1:0]  tag_arr   [256];
  logic              valid_arr [256];
  logic              dirty_arr [256];
  logic [LINE_W-1:0] data_arr  [256];

  assign tag_rd       = tag_arr[index];
  assign tag_valid_rd = valid_arr[index];
  assign tag_dirty_rd = dirty_arr[index];
  assign data_rd      = data_arr[index];

  cache_ctrl_fsm_p #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_valid_i(cpu_valid), .cpu_rw_i(cpu_rw), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
    .index_o(index), .tag_rd_i(tag_rd), .tag_valid_i(tag_valid_rd), .tag_dirty_i(tag_dirty_rd),
    .tag_we_o(tag_we), .tag_wr_o(tag_wr), .tag_valid_o(tag_valid_wr), .tag_dirty_o(tag_dirty_wr),
    .data_rd_i(data_rd), .data_we_o(data_we), .data_wr_o(data_wr),
    .mem_req_valid_o(mem_req_valid), .mem_req_rw_o(mem_req_rw), .mem_req_addr_o(mem_req_addr),
    .mem_req_wdata_o(mem_req_wdata), .mem_req_ready_i(mem_req_ready),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .stall_o(stall), .no_acc_o(no_acc), .no_hit_o(no_hit), .no_miss_o(no_miss), .no_wb_o(no_wb)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic [31:0] bmem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];

  function automatic logic [31:0] rd_b(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rd_r(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  typedef struct {
    logic [31:0]       addr;
    logic              rw;
    logic [31:0]       rdata;
    logic [LINE_W-1:0] line;
    bit                hit;
    bit                dirty;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  exp_t  sb  [$];
  beat_t wbq [$];

  logic [TAG_W-1:0] m_tag [256];
  bit               m_v   [256];
  bit               m_d   [256];
  int               m_acc, m_hit, m_miss, m_wb;

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic model_req(input logic [31:0] a, input logic rw, input logic [31:0] wd);
    exp_t        e;
    logic [7:0]  idx;
    logic [31:0] ba;
    idx     = a[11:4];
    e.addr  = a;
    e.rw    = rw;
    e.hit   = m_v[idx] && (m_tag[idx] == a[31:12]);
    e.dirty = !e.hit && m_v[idx] && m_d[idx];
    m_acc++;
    m_hit++;
    if (!e.hit) begin
      m_miss++;
      if (e.dirty) begin
        m_wb++;
        for (int b = 0; b < LINE_WORDS; b++) begin
          ba = {m_tag[idx], idx, 2'(b), 2'b00};
          wbq.push_back('{addr: ba, data: rd_r(ba)});
        end
      end
      m_tag[idx] = a[31:12];
      m_v[idx]   = 1'b1;
      m_d[idx]   = 1'b0;
    end
    if (rw) begin
      rmem[a]  = wd;
      m_d[idx] = 1'b1;
    end
    e.rdata = rd_r(a);
    ba      = {a[31:4], 4'h0};
    e.line  = {rd_r(ba + 12), rd_r(ba + 8), rd_r(ba + 4), rd_r(ba)};
    sb.push_back(e);
  endtask

  // Tag/data arrays: capture strobes mid-cycle, commit just after the edge.
  initial begin
    logic              pw_tag, pw_data, pv, pd;
    logic [7:0]        pidx;
    logic [TAG_W-1:0]  ptag;
    logic [LINE_W-1:0] pline;
    forever begin
      @(negedge clk); #1;
      pw_tag = tag_we && rst_n;  pw_data = data_we && rst_n;
      pidx = index; ptag = tag_wr; pv = tag_valid_wr; pd = tag_dirty_wr; pline = data_wr;
      @(posedge clk); #1;
      if (pw_tag && rst_n) begin
        tag_arr[pidx] = ptag; valid_arr[pidx] = pv; dirty_arr[pidx] = pd;
      end
      if (pw_data && rst_n) data_arr[pidx] = pline;
    end
  end

  logic [31:0] rspq [$];
  int          rsp_sent = 0;
  bit          stall_beat2 = 0;
  int          hold = 0;
  logic [31:0] held_addr, held_data;

  // Memory controller model with random back-pressure, gaps and stray responses.
  initial begin
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rspq.delete();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
      end else begin
        if (rspq.size() > 0 && $urandom_range(0, 3) != 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = rspq.pop_front();
          rsp_sent++;
        end else begin
          mem_rsp_valid = (rspq.size() == 0) && ($urandom_range(0, 7) == 0);
          mem_rsp_data  = $urandom;
        end
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
          if (stall_beat2 && mem_req_rw && mem_req_addr[3:2] == 2'd2 && hold < 5) begin
            if (hold == 0) begin
              held_addr = mem_req_addr;
              held_data = mem_req_wdata;
            end else begin
              chk("stall_beat_addr", mem_req_addr, held_addr);
              chk("stall_beat_wdata", mem_req_wdata, held_data);
            end
            chk("stall_o_held", stall, 1);
            hold++;
          end else begin
            mem_req_ready = ($urandom_range(0, 2) != 0);
          end
          if (mem_req_ready) begin
            if (mem_req_rw) bmem[mem_req_addr] = mem_req_wdata;
            else for (int b = 0; b < LINE_WORDS; b++) rspq.push_back(rd_b(mem_req_addr + 32'(4 * b)));
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every completion and every accepted memory request.
  initial begin
    exp_t  e;
    beat_t wb;
    int    lat = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        lat = 0;
      end else begin
        if (cpu_ready) begin
          chk("pending_request", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("stall_on_hit", stall, 0);
            if (!e.rw) begin
              chk("rdata", cpu_rdata, e.rdata);
              chk("read_no_data_we", {tag_we, data_we}, 0);
            end else begin
              chk("write_data_we", data_we, 1);
              chk("write_line", data_wr, e.line);
              chk("write_tag", {tag_we, tag_valid_wr, tag_dirty_wr, tag_wr}, {3'b111, e.addr[31:12]});
            end
            if (e.hit) chk("hit_latency", lat, 1);
            else chk("miss_latency_min", lat >= (e.dirty ? 3 + 2 * LINE_WORDS : 3 + LINE_WORDS), 1);
          end
          lat = 0;
        end else if (cpu_valid) begin
          lat++;
        end
        if (mem_req_valid && mem_req_ready) begin
          if (mem_req_rw) begin
            chk("wb_expected", wbq.size() != 0, 1);
            if (wbq.size() != 0) begin
              wb = wbq.pop_front();
              chk("wb_addr", mem_req_addr, wb.addr);
              chk("wb_data", mem_req_wdata, wb.data);
            end
          end else if (sb.size() != 0) begin
            chk("alloc_addr", mem_req_addr, {sb[0].addr[31:4], 4'h0});
            chk("alloc_only_on_miss", sb[0].hit, 0);
          end
        end
      end
    end
  end

  task automatic check_counters(input string tagname);
    chk({tagname, "_acc"}, no_acc, sat(m_acc));
    chk({tagname, "_hit"}, no_hit, sat(m_hit));
    chk({tagname, "_miss"}, no_miss, sat(m_miss));
    chk({tagname, "_wb"}, no_wb, sat(m_wb));
  endtask

  task automatic do_req(input logic [31:0] a, input logic rw, input logic [31:0] wd);
    bit got;
    model_req(a, rw, wd);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
    got = 1'b0;
    for (int cyc = 0; cyc < 500 && !got; cyc++) begin
      @(negedge clk);
      got = cpu_ready;
    end
    cpu_valid = 1'b0;
    if (!got) chk("request_timeout", got, 1);
    @(negedge clk);
  endtask

  initial begin
    logic [19:0] tags [4];
    int          base;
    tags[0] = 20'h0; tags[1] = 20'h1; tags[2] = 20'h2; tags[3] = 20'h100;
    for (int i = 0; i < 256; i++) begin
      tag_arr[i] = '0; valid_arr[i] = 1'b0; dirty_arr[i] = 1'b0; data_arr[i] = '0;
      m_tag[i] = '0; m_v[i] = 1'b0; m_d[i] = 1'b0;
    end
    m_acc = 0; m_hit = 0; m_miss = 0; m_wb = 0;
    cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {cpu_ready, mem_req_valid, stall, tag_we, data_we}, 0);
    chk("reset_data_outs", {cpu_rdata, mem_req_addr, mem_req_wdata}, 0);
    check_counters("reset");
    rst_n = 1'b1;

    do_req(32'h0000_0104, 1'b0, '0);
    check_counters("first_miss");
    do_req(32'h0000_0108, 1'b0, '0);
    check_counters("read_hit");
    do_req(32'h0000_0100, 1'b1, 32'hDEAD_BEEF);
    check_counters("write_hit");
    hold = 0;
    stall_beat2 = 1;
    do_req(32'h0010_0100, 1'b0, '0);
    stall_beat2 = 0;
    chk("stall_hold_cycles", hold, 5);
    check_counters("dirty_miss");

    for (int i = 0; i < 280; i++)
      do_req({tags[$urandom_range(0, 3)], 8'h10 + 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00},
             1'($urandom_range(0, 1)), $urandom);
    chk("scoreboard_drained", sb.size(), 0);
    chk("wb_queue_drained", wbq.size(), 0);
    check_counters("saturated");

    base = rsp_sent;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h0000_0800;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk); #2;
      if (rsp_sent >= base + 2) break;
    end
    chk("refill_reached_beat2", rsp_sent >= base + 2, 1);
    @(negedge clk);
    rst_n = 1'b0;
    cpu_valid = 1'b0;
    #1;
    chk("midburst_reset_strobes", {cpu_ready, mem_req_valid, stall, tag_we, data_we}, 0);
    m_acc = 0; m_hit = 0; m_miss = 0; m_wb = 0;
    check_counters("midburst_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("no_install_after_reset", valid_arr[8'h80], 0);
    do_req(32'h0000_0800, 1'b0, '0);
    check_counters("after_reset_miss");
    chk("final_scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
